mem_burst_master: RTL

//  Initiator side of the memory port (address/data_in/access_size/rw/enable/busy/data_out).

---
 rtl/mem_burst_master_pkg.sv | 41 ++++
 rtl/mem_burst_master_if.sv | 23 ++
 rtl/mem_burst_master_line_buffer.sv | 51 +++++
 rtl/mem_burst_master.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_burst_master_pkg.sv
// rtl/mem_burst_master_pkg.sv - shared encodings, FSM states and beat helpers
// Memory access_size codes, rw polarity and burst-length helpers.
package mem_pkg;

  localparam logic [1:0] SIZE_1  = 2'b00;
  localparam logic [1:0] SIZE_4  = 2'b01;
  localparam logic [1:0] SIZE_8  = 2'b10;
  localparam logic [1:0] SIZE_16 = 2'b11;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ISSUE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic logic [4:0] beats(input logic [1:0] size);
    case (size)
      SIZE_1:  return 5'd1;
      SIZE_4:  return 5'd4;
      SIZE_8:  return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

  // Index of the final beat; the beat counter saturates here.
  function automatic logic [3:0] last_beat(input logic [1:0] size);
    case (size)
      SIZE_1:  return 4'd0;
      SIZE_4:  return 4'd3;
      SIZE_8:  return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

endpackage

// File: rtl/mem_burst_master_if.sv
// rtl/mem_burst_master_if.sv - memory port bundle between burst master and memory
// Master drives the command/write side; memory returns busy and read data.
interface mem_burst_master_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       address;
  logic [DATA_W-1:0] data_in;
  logic [1:0]        access_size;
  logic              rw;
  logic              enable;
  logic              busy;
  logic [DATA_W-1:0] data_out;

  modport master (
    output address, data_in, access_size, rw, enable,
    input  busy, data_out
  );

  modport slave (
    input  address, data_in, access_size, rw, enable,
    output busy, data_out
  );
endinterface

// File: rtl/mem_burst_master_line_buffer.sv
// rtl/mem_burst_master_line_buffer.sv - write-burst line buffer (mem_line_buffer)
// Beats are stored in arrival order and read back by beat index during the burst.
module mem_line_buffer #(
  parameter  int DATA_W    = 32,
  parameter  int MAX_BEATS = 16,
  localparam int PTR_W     = $clog2(MAX_BEATS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [PTR_W:0]    count,
  output logic              full
);

  localparam logic [PTR_W:0] DEPTH = MAX_BEATS[PTR_W:0];

  logic [DATA_W-1:0] mem_q [MAX_BEATS];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              push;

  assign full    = (count_q == DEPTH);
  assign push    = wr_en && !full && !clear;
  assign count   = count_q;
  assign rd_data = mem_q[rd_idx];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (push) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      count_q  <= count_q + 1'b1;
    end
  end

  // Storage needs no reset: nothing reads a slot before it is written in FILL.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - request-to-burst initiator for one memory port
// Optional address rejection: define MEM_BURST_ALIGN_CHECK_EN.
module mem_burst_master
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8002_0000,
  parameter int          DATA_W    = 32,
  parameter int          MAX_BEATS = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  output logic              rdata_last,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  mem_burst_master_if.master mem
);

  localparam int PTR_W = $clog2(MAX_BEATS);

  state_t            state_q;
  state_t            state_d;
  logic [31:0]       addr_q;
  logic              rw_q;
  logic [1:0]        size_q;
  logic [3:0]        beat_q;
  logic [4:0]        n_beats;
  logic [3:0]        last_idx;
  logic              at_last;
  logic              acc;
  logic              req_bad;
  logic              fill_last;
  logic              buf_wr;
  logic              buf_clear;
  logic              buf_full;
  logic [PTR_W:0]    buf_count;
  logic [DATA_W-1:0] buf_rd_data;

  assign n_beats   = beats(size_q);
  assign last_idx  = last_beat(size_q);
  assign at_last   = (beat_q == last_idx);
  assign acc       = req_valid && req_ready;
  assign buf_wr    = (state_q == ST_FILL) && wdata_valid;
  assign buf_clear = (state_q == ST_DONE);
  assign fill_last = buf_wr && !buf_full && ((buf_count + 1'b1) == n_beats);

`ifdef MEM_BURST_ALIGN_CHECK_EN
  logic [31:0] align_mask;
  logic        err_q;

  // N*4-1 also covers the byte-offset bits, so a non-word address fails here too.
  assign align_mask = {25'd0, beats(req_size), 2'b00} - 32'd1;
  assign req_bad    = (req_addr < BASE_ADDR) || ((req_addr & align_mask) != 32'd0);
  assign err        = (state_q == ST_DONE) && err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (acc) begin
      err_q <= req_bad;
    end
  end
`else
  logic unused_cfg;

  assign req_bad    = 1'b0;
  assign err        = 1'b0;
  assign unused_cfg = ^{BASE_ADDR, req_addr[1:0]};
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      rw_q   <= 1'b0;
      size_q <= '0;
    end else if (acc) begin
      addr_q <= {req_addr[31:2], 2'b00};
      rw_q   <= req_rw;
      size_q <= req_size;
    end
  end

  // Beat 0 of a write leaves in ISSUE, so WRITE starts counting from 1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat_q <= '0;
    end else begin
      case (state_q)
        ST_ISSUE: begin
          if (!mem.busy) begin
            beat_q <= (rw_q == MEM_WRITE && last_idx != 4'd0) ? 4'd1 : 4'd0;
          end
        end
        ST_READ, ST_WRITE: begin
          if (!at_last) begin
            beat_q <= beat_q + 4'd1;
          end
        end
        default: beat_q <= 4'd0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          if (req_bad) begin
            state_d = ST_DONE;
          end else if (req_rw == MEM_READ) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (fill_last) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!mem.busy) begin
          if (rw_q == MEM_READ) begin
            state_d = ST_READ;
          end else if (last_idx == 4'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_READ, ST_WRITE: begin
        if (at_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // req_ready is gated by reset_n so every output reads 0 while reset is held.
  always_comb begin
    req_ready       = 1'b0;
    wdata_ready     = 1'b0;
    rdata_valid     = 1'b0;
    rdata_last      = 1'b0;
    rdata           = '0;
    done            = 1'b0;
    mem.address     = '0;
    mem.data_in     = '0;
    mem.access_size = '0;
    mem.rw          = 1'b0;
    mem.enable      = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = reset_n;
      ST_FILL: wdata_ready = !buf_full;
      ST_ISSUE, ST_WRITE: begin
        if (state_q == ST_WRITE || !mem.busy) begin
          mem.enable      = 1'b1;
          mem.address     = addr_q;
          mem.access_size = size_q;
          mem.rw          = rw_q;
          mem.data_in     = (rw_q == MEM_WRITE) ? buf_rd_data : '0;
        end
      end
      ST_READ: begin
        rdata_valid = 1'b1;
        rdata_last  = at_last;
        rdata       = mem.data_out;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  mem_line_buffer #(
    .DATA_W    (DATA_W),
    .MAX_BEATS (MAX_BEATS)
  ) u_line_buffer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (buf_clear),
    .wr_en   (buf_wr),
    .wr_data (wdata),
    .rd_idx  (beat_q[PTR_W-1:0]),
    .rd_data (buf_rd_data),
    .count   (buf_count),
    .full    (buf_full)
  );

endmodule
